tt_sel_seq: RTL and testbench
=============================

# tt_sel_seq

Selection sequencer that drives the multiplexer's three control pads (`ctrl_sel_rst_n`, `ctrl_sel_inc`, `ctrl_ena`) from a simple command interface. It sits between the management-side logic and the `tt_ctrl` pad inputs. It converts "select design N, optionally enable it" into the required reset/increment/enable pulse train. It tracks the currently selected address so that forward moves take the short path and skip the reset.

## Interface

Parameters:

- `ADDR_W`, 10: width of the design address.
- `MAX_ADDR`, 383: highest valid address (`G_X*G_Y - 1` for the default grid).
- `PULSE_CYC`, 4: cycles per pulse phase, high or low. Must be ≥1.

Ports:

- `clk` input 1: single clock.
- `rst` input 1: synchronous reset, active-high.
- `cmd_valid` input 1: command request.
- `cmd_ready` output 1: sequencer idle, can accept a command.
- `cmd_addr` input ADDR_W: target design address.
- `cmd_ena` input 1: drive `ctrl_ena` high after the selection completes.
- `done` output 1: one-cycle pulse when a command completes.
- `err` output 1: one-cycle pulse when a command is rejected.
- `cur_addr` output ADDR_W: currently selected address.
- `cur_valid` output 1: `cur_addr` reflects the mux state.
- `ctrl_sel_rst_n` output 1: to the mux selection reset, active-low.
- `ctrl_sel_inc` output 1: to the mux selection increment.
- `ctrl_ena` output 1: to the mux enable.

## Operation

- **Accept.** A command is accepted on any edge where `cmd_valid && cmd_ready`. `cmd_addr` and `cmd_ena` are latched. `cmd_ready` is high only in IDLE.
- **Reject.**
  - If `cmd_addr > MAX_ADDR`, the command is not executed.
  - `err` pulses in the cycle after accept.
  - The state stays IDLE and all outputs are unchanged.
- **Path choice at accept.**
  - Incremental path if `cur_valid && cmd_addr >= cur_addr`, with `n = cmd_addr - cur_addr`.
  - Otherwise full path, with `n = cmd_addr`.
- **States:** IDLE, RST_LO, RST_HI, INC_HI, INC_LO, FIN.
  - IDLE: `ctrl_ena` = stored enable bit; `ctrl_sel_rst_n`=1, `ctrl_sel_inc`=0.
  - RST_LO: `ctrl_sel_rst_n`=0 for PULSE_CYC cycles; `cur_valid` cleared; `cur_addr` set to 0.
  - RST_HI: `ctrl_sel_rst_n`=1 for PULSE_CYC cycles.
  - INC_HI: `ctrl_sel_inc`=1 for PULSE_CYC cycles.
  - INC_LO: `ctrl_sel_inc`=0 for PULSE_CYC cycles; `cur_addr` increments by 1 on exit.
  - FIN: for one cycle, `cur_valid`=1, enable bit ← latched `cmd_ena`, `done`=1. Then go to IDLE.
- **Transitions.**
  - Full path: IDLE → RST_LO → RST_HI.
  - Incremental path: IDLE → INC_HI, or IDLE → FIN if `n`=0.
  - After RST_HI: INC_HI if `n`>0, else FIN.
  - INC_HI → INC_LO.
  - INC_LO → INC_HI while pulses remain, else FIN.
- **`ctrl_ena`** is 0 in every state except IDLE. It is never high while the selection changes.
- **Counters.**
  - Phase counter is `$clog2(PULSE_CYC+1)` bits.
  - Pulse counter is ADDR_W bits, loaded with `n`, decremented per INC_LO exit.
  - No wrap: `n ≤ MAX_ADDR` is guaranteed by the reject rule.
- **Reset values** (also apply on `rst` mid-sequence):
  - state IDLE, `ctrl_sel_rst_n`=0, `ctrl_sel_inc`=0, `ctrl_ena`=0.
  - `cur_valid`=0, `cur_addr`=0, `done`=0, `err`=0, `cmd_ready`=0.
  - The cycle after `rst` deasserts: `ctrl_sel_rst_n`=1 and `cmd_ready`=1.
  - The first command after reset always takes the full path.

## Timing

- All outputs are registered. No combinational path from `cmd_*` to `ctrl_*`.
- Take the accept edge as cycle 0. The first control change (`ctrl_ena`→0, plus `ctrl_sel_rst_n`→0 on the full path) is visible in cycle 1.
- `done` is high in cycle:
  - Full path: 2·PULSE_CYC·(1+n) + 1.
  - Incremental path: 2·PULSE_CYC·n + 1.
- `ctrl_ena` rises in the cycle after `done` (first IDLE cycle), if `cmd_ena`.
- `cmd_ready` is high in the first IDLE cycle after FIN. Back-to-back commands are therefore spaced by at least one idle cycle.
- Reject timing: `err` is high in cycle 1, `cmd_ready` stays high, and there is no `done`.
- Exactly n rising edges on `ctrl_sel_inc` per command.

## Test plan

- **Reset values:** assert `rst` 3 cycles → all outputs hold their reset values. The cycle after release: `ctrl_sel_rst_n`=1, `cmd_ready`=1.
- **Full select:** PULSE_CYC=2, cmd addr=3, ena=1.
  - `ctrl_sel_rst_n` low in cycles 1–2.
  - 3 inc pulses, each high 2 cycles.
  - `done` in cycle 17; `ctrl_ena`=1 from cycle 18; `cur_addr`=3.
- **Incremental then downward:**
  - From addr 3, cmd addr=5 → no reset pulse, 2 inc pulses, `done` in cycle 9.
  - Then cmd addr=2 → reset pulse plus 2 inc pulses; `cur_addr`=2.
- **Zero cases:**
  - Cmd addr=0 after reset → reset pulse only; `done` in cycle 5.
  - Repeat the same addr with ena=0 → `done` in cycle 1; `ctrl_ena` goes 0; no inc pulse.
- **Reject:** cmd addr=MAX_ADDR+1 → `err` in cycle 1, no control-pad change, `cur_addr`/`cur_valid` unchanged, `ctrl_ena` keeps its previous value.
- **Reset mid-operation:** assert `rst` during the 2nd INC_HI of a full select → `ctrl_sel_inc`=0, `ctrl_ena`=0, `cur_valid`=0. The next cmd addr=1 takes the full path (reset pulse observed).

Source files
------------

// File: rtl/tt_sel_seq.sv
// Selection sequencer for the tt_ctrl mux pads.
// It turns "select address N, optionally enable" into the reset/increment/enable pulse train.
module tt_sel_seq #(
    parameter int unsigned ADDR_W    = 10,
    parameter int unsigned MAX_ADDR  = 383,
    parameter int unsigned PULSE_CYC = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [ADDR_W-1:0] cmd_addr,
    input  logic              cmd_ena,
    output logic              done,
    output logic              err,
    output logic [ADDR_W-1:0] cur_addr,
    output logic              cur_valid,
    output logic              ctrl_sel_rst_n,
    output logic              ctrl_sel_inc,
    output logic              ctrl_ena
);

    localparam int unsigned       PhW     = $clog2(PULSE_CYC + 1);
    localparam logic [PhW-1:0]    PhLoad  = PhW'(PULSE_CYC - 1);
    localparam logic [ADDR_W-1:0] MaxAddr = ADDR_W'(MAX_ADDR);

    typedef enum logic [2:0] {
        StIdle,
        StRstLo,
        StRstHi,
        StIncHi,
        StIncLo,
        StFin
    } state_e;

    state_e            state_q, state_d;
    logic [PhW-1:0]    phase_q, phase_d;
    logic [ADDR_W-1:0] pulse_q, pulse_d;
    logic              ena_lat_q, ena_lat_d;
    logic              ena_q, ena_d;
    logic [ADDR_W-1:0] cur_addr_q, cur_addr_d;
    logic              cur_valid_q, cur_valid_d;

    logic cmd_ready_q, cmd_ready_d;
    logic done_q, done_d;
    logic err_q, err_d;
    logic rst_n_q, rst_n_d;
    logic inc_q, inc_d;
    logic ctrl_ena_q, ctrl_ena_d;

    logic              accept;
    logic              phase_end;
    logic              incr_ok;
    logic [ADDR_W-1:0] diff;

    always_comb begin
        state_d     = state_q;
        phase_d     = phase_q;
        pulse_d     = pulse_q;
        ena_lat_d   = ena_lat_q;
        ena_d       = ena_q;
        cur_addr_d  = cur_addr_q;
        cur_valid_d = cur_valid_q;
        err_d       = 1'b0;

        // cmd_ready_q is only ever high while idle, so it doubles as the accept qualifier.
        accept    = cmd_valid && cmd_ready_q;
        phase_end = (phase_q == '0);
        incr_ok   = cur_valid_q && (cmd_addr >= cur_addr_q);
        diff      = cmd_addr - cur_addr_q;

        if (!phase_end) begin
            phase_d = phase_q - PhW'(1);
        end

        unique case (state_q)
            StIdle: begin
                if (accept) begin
                    if (cmd_addr > MaxAddr) begin
                        err_d = 1'b1;
                    end else begin
                        ena_lat_d = cmd_ena;
                        phase_d   = PhLoad;
                        if (incr_ok) begin
                            pulse_d = diff;
                            state_d = (diff == '0) ? StFin : StIncHi;
                        end else begin
                            pulse_d = cmd_addr;
                            state_d = StRstLo;
                        end
                    end
                end
            end
            StRstLo: begin
                if (phase_end) begin
                    state_d = StRstHi;
                    phase_d = PhLoad;
                end
            end
            StRstHi: begin
                if (phase_end) begin
                    phase_d = PhLoad;
                    state_d = (pulse_q != '0) ? StIncHi : StFin;
                end
            end
            StIncHi: begin
                if (phase_end) begin
                    state_d = StIncLo;
                    phase_d = PhLoad;
                end
            end
            StIncLo: begin
                if (phase_end) begin
                    cur_addr_d = cur_addr_q + ADDR_W'(1);
                    pulse_d    = pulse_q - ADDR_W'(1);
                    phase_d    = PhLoad;
                    state_d    = (pulse_q == ADDR_W'(1)) ? StFin : StIncHi;
                end
            end
            StFin: begin
                ena_d   = ena_lat_q;
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase

        // The mux address is unknown from the moment its selection reset is asserted.
        if (state_d == StRstLo) begin
            cur_valid_d = 1'b0;
            cur_addr_d  = '0;
        end
        if (state_d == StFin) begin
            cur_valid_d = 1'b1;
        end

        // Outputs are registered from the next state so the pads never glitch on cmd_*.
        cmd_ready_d = (state_d == StIdle);
        done_d      = (state_d == StFin);
        rst_n_d     = (state_d != StRstLo);
        inc_d       = (state_d == StIncHi);
        ctrl_ena_d  = (state_d == StIdle) && ena_d;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= StIdle;
            phase_q     <= '0;
            pulse_q     <= '0;
            ena_lat_q   <= 1'b0;
            ena_q       <= 1'b0;
            cur_addr_q  <= '0;
            cur_valid_q <= 1'b0;
            cmd_ready_q <= 1'b0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
            rst_n_q     <= 1'b0;
            inc_q       <= 1'b0;
            ctrl_ena_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            phase_q     <= phase_d;
            pulse_q     <= pulse_d;
            ena_lat_q   <= ena_lat_d;
            ena_q       <= ena_d;
            cur_addr_q  <= cur_addr_d;
            cur_valid_q <= cur_valid_d;
            cmd_ready_q <= cmd_ready_d;
            done_q      <= done_d;
            err_q       <= err_d;
            rst_n_q     <= rst_n_d;
            inc_q       <= inc_d;
            ctrl_ena_q  <= ctrl_ena_d;
        end
    end

    assign cmd_ready      = cmd_ready_q;
    assign done           = done_q;
    assign err            = err_q;
    assign cur_addr       = cur_addr_q;
    assign cur_valid      = cur_valid_q;
    assign ctrl_sel_rst_n = rst_n_q;
    assign ctrl_sel_inc   = inc_q;
    assign ctrl_ena       = ctrl_ena_q;

endmodule

// File: tb/tb_tt_sel_seq.sv
// Self-checking bench for tt_sel_seq: directed steps plus random commands
// checked against an arithmetic model of the selection timing.
module tb_tt_sel_seq;

    localparam int unsigned AW   = 10;
    localparam int unsigned MAXA = 383;
    localparam int unsigned P    = 2;

    logic          clk = 1'b0;
    logic          rst;
    logic          cmd_valid;
    logic          cmd_ready;
    logic [AW-1:0] cmd_addr;
    logic          cmd_ena;
    logic          done;
    logic          err;
    logic [AW-1:0] cur_addr;
    logic          cur_valid;
    logic          ctrl_sel_rst_n;
    logic          ctrl_sel_inc;
    logic          ctrl_ena;

    tt_sel_seq #(
        .ADDR_W   (AW),
        .MAX_ADDR (MAXA),
        .PULSE_CYC(P)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .cmd_valid     (cmd_valid),
        .cmd_ready     (cmd_ready),
        .cmd_addr      (cmd_addr),
        .cmd_ena       (cmd_ena),
        .done          (done),
        .err           (err),
        .cur_addr      (cur_addr),
        .cur_valid     (cur_valid),
        .ctrl_sel_rst_n(ctrl_sel_rst_n),
        .ctrl_sel_inc  (ctrl_sel_inc),
        .ctrl_ena      (ctrl_ena)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int fails  = 0;

    // Reference view of the mux: what it currently selects and whether that is known.
    bit m_valid = 1'b0;
    int m_addr  = 0;
    bit m_ena   = 1'b0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_valid = 1'b0;
        m_addr  = 0;
        m_ena   = 1'b0;
    endtask

    task automatic wait_ready(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 4000; i++) begin
            if (cmd_ready === 1'b1) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
    endtask

    task automatic do_reset(input int cycles);
        rst = 1'b1;
        repeat (cycles) @(negedge clk);
        rst = 1'b0;
        model_reset();
        @(negedge clk);
    endtask

    // Issue one command and follow it cycle by cycle; cycle k is the k-th period after accept.
    task automatic run_cmd(input int addr, input bit ena, input int want_done);
        bit   ok;
        bit   full;
        int   n;
        int   exp_done;
        int   done_cyc;
        int   rst_lo;
        int   rst_first;
        int   inc_edges;
        int   ena_bad;
        int   err_seen;
        int   extra_done;
        logic prev_inc;

        wait_ready(ok);
        if (!ok) begin
            check("ready_timeout", 0, 1);
            return;
        end
        cmd_addr  = AW'(addr);
        cmd_ena   = ena;
        cmd_valid = 1'b1;
        @(posedge clk);

        if (addr > int'(MAXA)) begin
            @(negedge clk);
            cmd_valid = 1'b0;
            check("rej_err", err, 1);
            check("rej_ready", cmd_ready, 1);
            check("rej_rst_n", ctrl_sel_rst_n, 1);
            check("rej_inc", ctrl_sel_inc, 0);
            check("rej_ena", ctrl_ena, m_ena);
            check("rej_cur_addr", cur_addr, m_addr);
            check("rej_cur_valid", cur_valid, m_valid);
            extra_done = 0;
            repeat (4) begin
                @(negedge clk);
                if (done !== 1'b0) extra_done++;
            end
            check("rej_no_done", extra_done, 0);
            return;
        end

        full     = !m_valid || (addr < m_addr);
        n        = full ? addr : addr - m_addr;
        exp_done = full ? 2 * P * (1 + n) + 1 : 2 * P * n + 1;

        done_cyc  = -1;
        rst_lo    = 0;
        rst_first = -1;
        inc_edges = 0;
        ena_bad   = 0;
        err_seen  = 0;
        prev_inc  = 1'b0;
        for (int k = 1; k <= exp_done + 4 && done_cyc < 0; k++) begin
            @(negedge clk);
            if (k == 1) cmd_valid = 1'b0;
            if (ctrl_sel_rst_n !== 1'b1) begin
                rst_lo++;
                if (rst_first < 0) rst_first = k;
            end
            if (ctrl_sel_inc === 1'b1 && prev_inc !== 1'b1) inc_edges++;
            prev_inc = ctrl_sel_inc;
            if (ctrl_ena !== 1'b0) ena_bad++;
            if (err !== 1'b0) err_seen++;
            if (done === 1'b1) done_cyc = k;
        end

        check("done_cycle", done_cyc, exp_done);
        if (want_done >= 0) check("done_plan", done_cyc, want_done);
        check("rst_low_cycles", rst_lo, full ? P : 0);
        if (full) check("rst_first_cycle", rst_first, 1);
        check("inc_edges", inc_edges, n);
        check("ena_low_during", ena_bad, 0);
        check("no_err", err_seen, 0);

        @(negedge clk);
        check("post_ena", ctrl_ena, ena);
        check("post_ready", cmd_ready, 1);
        check("post_cur_addr", cur_addr, addr);
        check("post_cur_valid", cur_valid, 1);
        check("post_done_low", done, 0);

        m_valid = 1'b1;
        m_addr  = addr;
        m_ena   = ena;
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int  addr;
        int  r;
        bit  ok;

        rst       = 1'b1;
        cmd_valid = 1'b0;
        cmd_addr  = '0;
        cmd_ena   = 1'b0;

        // Reset values after three cycles of rst.
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_rst_n", ctrl_sel_rst_n, 0);
        check("rst_inc", ctrl_sel_inc, 0);
        check("rst_ena", ctrl_ena, 0);
        check("rst_cur_valid", cur_valid, 0);
        check("rst_cur_addr", cur_addr, 0);
        check("rst_done", done, 0);
        check("rst_err", err, 0);
        check("rst_ready", cmd_ready, 0);
        rst = 1'b0;
        @(negedge clk);
        check("rel_rst_n", ctrl_sel_rst_n, 1);
        check("rel_ready", cmd_ready, 1);

        // Full select, incremental forward, then a downward move.
        run_cmd(3, 1'b1, 17);
        run_cmd(5, 1'b1, 9);
        run_cmd(2, 1'b1, 13);

        // Zero cases and a reject with the enable held high.
        do_reset(2);
        run_cmd(0, 1'b1, 5);
        run_cmd(int'(MAXA) + 1, 1'b1, -1);
        run_cmd(0, 1'b0, 1);

        // Reset during the second increment pulse of a full select.
        do_reset(2);
        wait_ready(ok);
        check("mid_ready", ok, 1);
        cmd_addr  = AW'(3);
        cmd_ena   = 1'b1;
        cmd_valid = 1'b1;
        @(posedge clk);
        for (int k = 1; k <= 9; k++) begin
            @(negedge clk);
            if (k == 1) cmd_valid = 1'b0;
        end
        check("mid_in_inc_hi", ctrl_sel_inc, 1);
        rst = 1'b1;
        @(negedge clk);
        check("mid_inc", ctrl_sel_inc, 0);
        check("mid_ena", ctrl_ena, 0);
        check("mid_cur_valid", cur_valid, 0);
        check("mid_cur_addr", cur_addr, 0);
        check("mid_ready_low", cmd_ready, 0);
        @(negedge clk);
        rst = 1'b0;
        model_reset();
        @(negedge clk);
        run_cmd(1, 1'b1, 9);

        // Boundary: top address, then one past it.
        run_cmd(int'(MAXA), 1'b0, -1);
        run_cmd(int'(MAXA) + 1, 1'b0, -1);

        // Random mix of forward, backward, repeat and rejected commands.
        for (int i = 0; i < 25; i++) begin
            r = int'($urandom_range(0, 9));
            if (r == 0) begin
                addr = int'($urandom_range(MAXA + 1, 1023));
            end else if (r < 5) begin
                addr = m_addr + int'($urandom_range(0, 4));
                if (addr > int'(MAXA)) addr = int'(MAXA);
            end else begin
                addr = int'($urandom_range(0, 30));
            end
            run_cmd(addr, 1'($urandom_range(0, 1)), -1);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
